jfq_acc_ctrl: RTL and testbench

//  Sequencing stage around the combinational 4-bit saturating signed adder (Jfq).
//  - Captures operands over a valid/ready handshake and drives a/b/Cin into the adder.
//  - Waits a settle window, then registers Result/Cout and a local overflow flag.
//  - Presents the registered result downstream over valid/ready.
//  - Optional accumulate mode feeds the previous saturated result back as operand A.

---
 rtl/jfq_acc_ctrl.sv | 163 ++++++++++++++++
 tb/tb_jfq_acc_ctrl.sv | 370 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jfq_acc_ctrl.sv
// jfq_acc_ctrl: sequencing stage around the external 4-bit saturating signed
// adder. It accepts operands over valid/ready and holds them on add_* for a
// settle window. It then registers the adder's result with a locally computed
// overflow flag, and offers that result downstream over valid/ready. In
// accumulate mode the previous saturated result replaces operand A.
module jfq_acc_ctrl #(
    parameter int SETTLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       in_a,
    input  logic [3:0]       in_b,
    input  logic             in_cin,
    input  logic             acc_mode,
    input  logic             clr,
    output logic [3:0]       add_a,
    output logic [3:0]       add_b,
    output logic             add_cin,
    input  logic [3:0]       add_result,
    input  logic             add_cout,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_sum,
    output logic             out_cout,
    output logic             out_sat,
    output logic [CNT_W-1:0] op_cnt
);

    typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, HOLD} state_t;

    state_t                 state_q, state_d;
    logic [3:0]             settle_q, settle_d;
    logic signed [3:0]      a_q, a_d;
    logic signed [3:0]      b_q, b_d;
    logic                   cin_q, cin_d;
    logic                   mode_q, mode_d;
    logic signed [3:0]      acc_q, acc_d;
    logic signed [3:0]      sum_q, sum_d;
    logic                   cout_q, cout_d;
    logic                   sat_q, sat_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;

    // An overflow is flagged when the exact 5-bit sum leaves -8..7. It is
    // flagged only if the adder actually clamped to the matching rail.
    function automatic logic sat_check(input logic signed [3:0] a,
                                       input logic signed [3:0] b,
                                       input logic              cin,
                                       input logic [3:0]        res);
        logic [4:0] s;
        s = {a[3], a} + {b[3], b} + {4'b0000, cin};
        if (s[4] == s[3]) begin
            return 1'b0;
        end else if (!s[4]) begin
            return (res == 4'b0111);
        end else begin
            return (res == 4'b1000);
        end
    endfunction

    // Next-state and datapath capture for the IDLE/DRIVE/SAMPLE/HOLD sequence
    always_comb begin
        state_d  = state_q;
        settle_d = settle_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        mode_d   = mode_q;
        acc_d    = acc_q;
        sum_d    = sum_q;
        cout_d   = cout_q;
        sat_d    = sat_q;
        cnt_d    = cnt_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // A clear arriving with the accept zeroes the fed-back operand.
                    if (acc_mode) begin
                        a_d = clr ? 4'sd0 : acc_q;
                    end else begin
                        a_d = in_a;
                    end
                    b_d      = in_b;
                    cin_d    = in_cin;
                    mode_d   = acc_mode;
                    settle_d = 4'd0;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (settle_q == 4'(SETTLE_CYC - 1)) begin
                    state_d = SAMPLE;
                end else begin
                    settle_d = settle_q + 4'd1;
                end
            end
            SAMPLE: begin
                sum_d  = add_result;
                cout_d = add_cout;
                sat_d  = sat_check(a_q, b_q, cin_q, add_result);
                if (mode_q) begin
                    acc_d = add_result;
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (out_ready) begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Clear beats any accumulator update, in every state.
        if (clr) begin
            acc_d = 4'sd0;
        end
    end

    // State and data registers; reset discards any operation in flight
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            settle_q <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            mode_q   <= 1'b0;
            acc_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
            sat_q    <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            mode_q   <= mode_d;
            acc_q    <= acc_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
            sat_q    <= sat_d;
            cnt_q    <= cnt_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == HOLD);
    assign add_a     = a_q;
    assign add_b     = b_q;
    assign add_cin   = cin_q;
    assign out_sum   = sum_q;
    assign out_cout  = cout_q;
    assign out_sat   = sat_q;
    assign op_cnt    = cnt_q;

endmodule

// File: tb/tb_jfq_acc_ctrl.sv
// Testbench for jfq_acc_ctrl: models the external saturating adder, drives
// directed and random operations, and checks results against an arithmetic
// reference model.
module tb_jfq_acc_ctrl;

    localparam int SETTLE = 1;
    localparam int CNT_W  = 8;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_a;
    logic [3:0]       in_b;
    logic             in_cin;
    logic             acc_mode;
    logic             clr;
    logic [3:0]       add_a;
    logic [3:0]       add_b;
    logic             add_cin;
    logic [3:0]       add_result;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_sum;
    logic             out_cout;
    logic             out_sat;
    logic [CNT_W-1:0] op_cnt;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    int acc_m = 0;

    typedef struct {
        logic [3:0] sum;
        logic       cout;
        logic       sat;
    } exp_t;

    jfq_acc_ctrl #(.SETTLE_CYC(SETTLE), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_cin(in_cin), .acc_mode(acc_mode), .clr(clr),
        .add_a(add_a), .add_b(add_b), .add_cin(add_cin),
        .add_result(add_result), .add_cout(add_cout),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_cout(out_cout), .out_sat(out_sat), .op_cnt(op_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural model of the combinational saturating adder
    int adder_s;
    int adder_u;
    always_comb begin
        adder_s = $signed(add_a) + $signed(add_b) + int'(add_cin);
        adder_u = int'(add_a) + int'(add_b) + int'(add_cin);
        add_cout = (adder_u > 15);
        if (adder_s > 7)       add_result = 4'b0111;
        else if (adder_s < -8) add_result = 4'b1000;
        else                   add_result = adder_s[3:0];
    end

    function automatic int s4(input logic [3:0] v);
        return v[3] ? int'(v) - 16 : int'(v);
    endfunction

    // Reference: exact signed sum clamped to -8..7, unsigned carry out of bit 3
    function automatic exp_t ref_op(input int a, input int b, input int cin);
        exp_t e;
        int s;
        int u;
        s = a + b + cin;
        u = (a & 15) + (b & 15) + cin;
        e.cout = (u > 15);
        if (s > 7)       begin e.sum = 4'b0111; e.sat = 1'b1; end
        else if (s < -8) begin e.sum = 4'b1000; e.sat = 1'b1; end
        else             begin e.sum = 4'(s);   e.sat = 1'b0; end
        return e;
    endfunction

    // Model-level operation: resolves operand A and updates the model accumulator
    function automatic exp_t model_op(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin, input logic mode, input logic c);
        exp_t e;
        int aop;
        if (c) acc_m = 0;
        aop = mode ? acc_m : s4(a);
        e = ref_op(aop, s4(b), int'(cin));
        if (mode) acc_m = s4(e.sum);
        return e;
    endfunction

    // Offer one operand set, let it be accepted, wait for out_valid; lat = cycles
    task automatic start_op(input logic [3:0] a, input logic [3:0] b, input logic cin,
                            input logic mode, input logic c, output int lat);
        int n;
        n = 0;
        lat = -1;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        if (!in_ready) return;
        in_valid = 1'b1; in_a = a; in_b = b; in_cin = cin; acc_mode = mode; clr = c;
        @(posedge clk); #1;
        in_valid = 1'b0; clr = 1'b0;
        lat = 0;
        while (!out_valid && lat < 50) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic finish_op();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        if (!out_valid) exp_cnt = (exp_cnt + 1) % 256;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0;
        acc_mode = 1'b0; clr = 1'b0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid);
        end
        checks++;
        if ({out_sum, out_cout, out_sat} !== 6'b0 || op_cnt !== '0) begin
            errors++; $display("FAIL reset_out sum=%b cout=%b sat=%b cnt=%0d want zeros", out_sum, out_cout, out_sat, op_cnt);
        end
        checks++;
        if ({add_a, add_b, add_cin} !== 9'b0) begin
            errors++; $display("FAIL reset_add a=%b b=%b cin=%b want zeros", add_a, add_b, add_cin);
        end
        rst_n = 1'b1;
        exp_cnt = 0; acc_m = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        int lat;
        exp_t e;
        start_op(4'd3, 4'd2, 1'b0, 1'b0, 1'b0, lat);
        e = model_op(4'd3, 4'd2, 1'b0, 1'b0, 1'b0);
        checks++;
        if (lat !== SETTLE + 1) begin
            errors++; $display("FAIL latency got %0d want %0d", lat, SETTLE + 1);
        end
        checks++;
        if (out_sum !== 4'b0101 || out_cout !== 1'b0 || out_sat !== 1'b0 || e.sum !== 4'b0101) begin
            errors++; $display("FAIL basic_3p2 sum=%b cout=%b sat=%b want 0101/0/0", out_sum, out_cout, out_sat);
        end
        finish_op();
        checks++;
        if (in_ready !== 1'b1 || op_cnt !== CNT_W'(exp_cnt)) begin
            errors++; $display("FAIL basic_done in_ready=%b cnt=%0d want 1/%0d", in_ready, op_cnt, exp_cnt);
        end
    endtask

    task automatic test_saturation();
        int lat;
        exp_t e;
        logic [3:0] a, b;
        logic cin;
        start_op(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0, lat);
        e = model_op(4'b0111, 4'b0001, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_sum !== 4'b0111 || out_sat !== 1'b1 || out_cout !== 1'b0) begin
            errors++; $display("FAIL sat_pos sum=%b cout=%b sat=%b want 0111/0/1", out_sum, out_cout, out_sat);
        end
        finish_op();
        start_op(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0, lat);
        e = model_op(4'b1000, 4'b1111, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_sum !== 4'b1000 || out_sat !== 1'b1 || out_cout !== 1'b1) begin
            errors++; $display("FAIL sat_neg sum=%b cout=%b sat=%b want 1000/1/1", out_sum, out_cout, out_sat);
        end
        finish_op();
        for (int i = 0; i < 24; i++) begin
            a = 4'($urandom_range(0, 15));
            b = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            start_op(a, b, cin, 1'b0, 1'b0, lat);
            e = model_op(a, b, cin, 1'b0, 1'b0);
            checks++;
            if (out_sum !== e.sum || out_cout !== e.cout || out_sat !== e.sat || lat !== SETTLE + 1) begin
                errors++; $display("FAIL rand_add a=%b b=%b cin=%b got %b/%b/%b lat %0d want %b/%b/%b", a, b, cin, out_sum, out_cout, out_sat, lat, e.sum, e.cout, e.sat);
            end
            finish_op();
        end
    endtask

    task automatic test_accumulate();
        int lat;
        exp_t e;
        logic [3:0] want_sum [4];
        logic       want_sat [4];
        logic [3:0] bv [4];
        want_sum[0] = 4'b0011; want_sat[0] = 1'b0; bv[0] = 4'd3;
        want_sum[1] = 4'b0110; want_sat[1] = 1'b0; bv[1] = 4'd3;
        want_sum[2] = 4'b0111; want_sat[2] = 1'b1; bv[2] = 4'd3;
        want_sum[3] = 4'b0111; want_sat[3] = 1'b0; bv[3] = 4'd0;
        clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0; acc_m = 0;
        for (int i = 0; i < 4; i++) begin
            start_op(4'($urandom_range(0, 15)), bv[i], 1'b0, 1'b1, 1'b0, lat);
            e = model_op(4'd0, bv[i], 1'b0, 1'b1, 1'b0);
            checks++;
            if (out_sum !== want_sum[i] || out_sat !== want_sat[i]) begin
                errors++; $display("FAIL acc_step%0d sum=%b sat=%b want %b/%b", i, out_sum, out_sat, want_sum[i], want_sat[i]);
            end
            finish_op();
        end
        for (int i = 0; i < 10; i++) begin
            logic [3:0] b;
            logic cin;
            b = 4'($urandom_range(0, 15));
            cin = 1'($urandom_range(0, 1));
            start_op(4'($urandom_range(0, 15)), b, cin, 1'b1, 1'b0, lat);
            e = model_op(4'd0, b, cin, 1'b1, 1'b0);
            checks++;
            if (out_sum !== e.sum || out_cout !== e.cout || out_sat !== e.sat) begin
                errors++; $display("FAIL acc_rand b=%b cin=%b got %b/%b/%b want %b/%b/%b", b, cin, out_sum, out_cout, out_sat, e.sum, e.cout, e.sat);
            end
            finish_op();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        exp_t e;
        start_op(4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0, lat);
        e = model_op(4'b0101, 4'b1110, 1'b1, 1'b0, 1'b0);
        in_valid = 1'b1; in_a = 4'b0001; in_b = 4'b0001; in_cin = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || op_cnt !== CNT_W'(exp_cnt) ||
                out_sum !== e.sum || out_cout !== e.cout || out_sat !== e.sat ||
                add_a !== 4'b0101 || add_b !== 4'b1110 || add_cin !== 1'b1) begin
                errors++; $display("FAIL hold_cyc%0d vld=%b rdy=%b cnt=%0d sum=%b add=%b/%b/%b want 1/0/%0d %b 0101/1110/1", i, out_valid, in_ready, op_cnt, out_sum, add_a, add_b, add_cin, exp_cnt, e.sum);
            end
        end
        in_valid = 1'b0;
        finish_op();
        checks++;
        if (op_cnt !== CNT_W'(exp_cnt) || out_valid !== 1'b0) begin
            errors++; $display("FAIL hold_release cnt=%0d vld=%b want %0d/0", op_cnt, out_valid, exp_cnt);
        end
    endtask

    task automatic test_reset_midop();
        int lat;
        exp_t e;
        start_op(4'd0, 4'd5, 1'b0, 1'b1, 1'b0, lat);
        e = model_op(4'd0, 4'd5, 1'b0, 1'b1, 1'b0);
        finish_op();
        in_valid = 1'b1; in_a = 4'd2; in_b = 4'd1; in_cin = 1'b0; acc_mode = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0; acc_m = 0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || op_cnt !== '0 || out_sum !== 4'b0) begin
            errors++; $display("FAIL rst_drive rdy=%b vld=%b cnt=%0d sum=%b want 1/0/0/0000", in_ready, out_valid, op_cnt, out_sum);
        end
        start_op(4'd0, 4'd2, 1'b0, 1'b1, 1'b0, lat);
        e = model_op(4'd0, 4'd2, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_sum !== 4'b0010) begin
            errors++; $display("FAIL rst_acc_zero sum=%b want 0010", out_sum);
        end
        finish_op();
        start_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0, lat);
        e = model_op(4'd1, 4'd1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (out_sum !== 4'b0010 || out_sat !== 1'b0) begin
            errors++; $display("FAIL rst_then_1p1 sum=%b sat=%b want 0010/0", out_sum, out_sat);
        end
        finish_op();
    endtask

    task automatic test_back_to_back();
        exp_t q[$];
        exp_t e;
        exp_t got;
        int cyc;
        int last_cyc;
        int transfers;
        int lat;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_cnt = 0; acc_m = 0;
        out_ready = 1'b1; in_valid = 1'b1; clr = 1'b0;
        in_a = 4'($urandom_range(0, 15)); in_b = 4'($urandom_range(0, 15));
        in_cin = 1'($urandom_range(0, 1)); acc_mode = 1'($urandom_range(0, 1));
        cyc = 0; last_cyc = -1; transfers = 0;
        while (transfers < 256 && cyc < 2000) begin
            @(negedge clk);
            if (out_valid) begin
                checks++;
                if (q.size() == 0) begin
                    errors++; $display("FAIL b2b_extra result %b with nothing outstanding", out_sum);
                end else begin
                    got = q.pop_front();
                    if (out_sum !== got.sum || out_cout !== got.cout || out_sat !== got.sat || op_cnt !== CNT_W'(exp_cnt)) begin
                        errors++; $display("FAIL b2b_op%0d got %b/%b/%b cnt %0d want %b/%b/%b cnt %0d", transfers, out_sum, out_cout, out_sat, op_cnt, got.sum, got.cout, got.sat, exp_cnt);
                    end
                end
                transfers++;
                exp_cnt = (exp_cnt + 1) % 256;
                last_cyc = cyc;
            end
            if (in_ready) begin
                e = model_op(in_a, in_b, in_cin, acc_mode, 1'b0);
                q.push_back(e);
            end
            @(posedge clk); #1;
            in_a = 4'($urandom_range(0, 15)); in_b = 4'($urandom_range(0, 15));
            in_cin = 1'($urandom_range(0, 1)); acc_mode = 1'($urandom_range(0, 1));
            cyc++;
        end
        in_valid = 1'b0; out_ready = 1'b0;
        checks++;
        if (transfers !== 256 || last_cyc !== (SETTLE + 3) * 255 + SETTLE + 2) begin
            errors++; $display("FAIL b2b_rate transfers=%0d last=%0d want 256/%0d", transfers, last_cyc, (SETTLE + 3) * 255 + SETTLE + 2);
        end
        checks++;
        if (op_cnt !== CNT_W'(exp_cnt) || exp_cnt != 0) begin
            errors++; $display("FAIL b2b_wrap cnt=%0d want 0", op_cnt);
        end
        // Make the accumulator non-zero, then clear it on the same edge as an accept
        start_op(4'd0, 4'd3, 1'b0, 1'b1, 1'b0, lat);
        e = model_op(4'd0, 4'd3, 1'b0, 1'b1, 1'b0);
        finish_op();
        start_op(4'd5, 4'd2, 1'b0, 1'b1, 1'b1, lat);
        e = model_op(4'd5, 4'd2, 1'b0, 1'b1, 1'b1);
        checks++;
        if (out_sum !== 4'b0010 || add_a !== 4'b0000 || e.sum !== 4'b0010) begin
            errors++; $display("FAIL clr_accept sum=%b add_a=%b want 0010/0000", out_sum, add_a);
        end
        finish_op();
        start_op(4'd0, 4'd1, 1'b0, 1'b1, 1'b0, lat);
        e = model_op(4'd0, 4'd1, 1'b0, 1'b1, 1'b0);
        checks++;
        if (out_sum !== e.sum) begin
            errors++; $display("FAIL clr_then_acc sum=%b want %b", out_sum, e.sum);
        end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_accumulate();
        test_backpressure();
        test_reset_midop();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
